fetch: RTL

Instruction fetch stage and PC owner. It is the consumer end of the execute stage's control-flow outputs: the branch targets and the eq/lt/ltu flags.
- Issues word requests to instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers returned instructions for decode.
- On a resolved taken branch or jump: redirects the PC, flushes queued instructions and discards in-flight responses.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: PC/data words and the control-flow kind decoded by execute.
package riscv;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] data_t;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    JAL  = 4'd1,
    JALR = 4'd2,
    BEQ  = 4'd3,
    BNE  = 4'd4,
    BLT  = 4'd5,
    BGE  = 4'd6,
    BLTU = 4'd7,
    BGEU = 4'd8
  } branch_t;

  localparam pc_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; flush overrides push and pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  // Head is forced to zero when empty so consumers see a clean value out of reset.
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(do_push);
      rd_q    <= rd_q + AW'(do_pop);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues imem requests under credit control,
// buffers responses for decode and redirects on taken control transfers from execute.
module fetch
  import riscv::*;
#(
  parameter pc_t         RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    ex_valid,
  input  branch_t ex_branch,
  input  logic    ex_eq,
  input  logic    ex_lt,
  input  logic    ex_ltu,
  input  pc_t     ex_jal_bxx_tgt,
  input  pc_t     ex_jalr_tgt,
  output logic    imem_req_valid,
  input  logic    imem_req_ready,
  output pc_t     imem_addr,
  input  logic    imem_rsp_valid,
  input  data_t   imem_rsp_data,
  output logic    if_valid,
  input  logic    if_ready,
  output pc_t     if_pc,
  output data_t   if_inst,
  output logic    redirect
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned KW = CW + 3;

  pc_t           pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;     // live (non-killed) requests in flight
  logic [KW-1:0] kill_q, kill_d;   // in-flight responses still to be discarded
  logic          run_q;

  logic          taken;
  pc_t           target;
  logic          req_fire, rsp_live, rsp_kill;

  logic [63:0]   ififo_head;
  logic          ififo_empty, ififo_full;
  logic [CW-1:0] ififo_cnt;
  pc_t           tag_pc;
  logic          tag_empty, tag_full;
  logic [CW-1:0] tag_cnt;

  always_comb begin
    taken = 1'b0;
    case (ex_branch)
      JAL, JALR: taken = 1'b1;
      BEQ:       taken = ex_eq;
      BNE:       taken = ~ex_eq;
      BLT:       taken = ex_lt;
      BGE:       taken = ~ex_lt;
      BLTU:      taken = ex_ltu;
      BGEU:      taken = ~ex_ltu;
      default:   taken = 1'b0;
    endcase
  end

  assign redirect = ex_valid & taken;
  assign target   = (ex_branch == JALR) ? {ex_jalr_tgt[31:2], 2'b00}
                                        : {ex_jal_bxx_tgt[31:2], 2'b00};

  // run_q holds requests off for the first cycle after reset release.
  assign imem_req_valid = run_q & ~redirect &
                          (({1'b0, out_q} + {1'b0, ififo_cnt}) < (CW + 1)'(FIFO_DEPTH));
  assign imem_addr = pc_q;
  assign req_fire  = imem_req_valid & imem_req_ready;
  assign rsp_kill  = imem_rsp_valid & (kill_q != '0);
  assign rsp_live  = imem_rsp_valid & (kill_q == '0) & ~redirect;

  assign if_valid = ~ififo_empty & ~redirect;
  assign if_pc    = ififo_head[63:32];
  assign if_inst  = ififo_head[31:0];

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_tag_q (
    .clk     (clk),
    .rst_n   (resetn),
    .flush_i (redirect),
    .push_i  (req_fire),
    .data_i  (pc_q),
    .pop_i   (rsp_live),
    .data_o  (tag_pc),
    .empty_o (tag_empty),
    .full_o  (tag_full),
    .count_o (tag_cnt)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_inst_q (
    .clk     (clk),
    .rst_n   (resetn),
    .flush_i (redirect),
    .push_i  (rsp_live),
    .data_i  ({tag_pc, imem_rsp_data}),
    .pop_i   (if_valid & if_ready),
    .data_o  (ififo_head),
    .empty_o (ififo_empty),
    .full_o  (ififo_full),
    .count_o (ififo_cnt)
  );

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    kill_d = kill_q;
    if (redirect) begin
      pc_d   = target;
      out_d  = '0;
      kill_d = kill_q + KW'(out_q) - KW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + PC_STEP;
      out_d  = out_q + CW'(req_fire) - CW'(rsp_live);
      kill_d = kill_q - KW'(rsp_kill);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q   <= RESET_VECTOR;
      out_q  <= '0;
      kill_q <= '0;
      run_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      kill_q <= kill_d;
      run_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      assert ({1'b0, out_q} + {1'b0, ififo_cnt} <= (CW + 1)'(FIFO_DEPTH));
      assert (tag_cnt == out_q);
      assert (!(rsp_live && tag_empty));
      assert (!(req_fire && tag_full));
      assert (!(rsp_live && ififo_full && !(if_valid && if_ready)));
    end
  end

endmodule
